// File: rtl/vector_read_sequencer.sv
// vector_read_sequencer: owns the shared port-B read side of the A/B vector
// BRAMs. It issues consecutive read addresses, absorbs the BRAM read latency
// and buffers aligned (A[i], B[i]) pairs in a small first-word-fall-through
// FIFO. The consumer drains the FIFO through a valid/ready handshake and may
// stall at any time without losing pairs or misaligning A and B.
module vector_read_sequencer #(
    parameter int NBytes     = 1024,
    parameter int READ_LAT   = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [$clog2(NBytes):0]   length,
    input  logic                      abort,
    output logic [$clog2(NBytes)-1:0] bram_addr,
    output logic                      rd_en,
    input  logic [7:0]                bramA_byte,
    input  logic [7:0]                bramB_byte,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [7:0]                out_a,
    output logic [7:0]                out_b,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int AW = $clog2(NBytes);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic [LW-1:0]       len;
    logic [LW-1:0]       issue_cnt;
    logic [LW-1:0]       last_idx;
    logic [LW-1:0]       len_clamped;
    logic                rd_last;

    // Read-latency pipe: one valid bit and one last flag per outstanding read.
    logic [READ_LAT-1:0] vld_p;
    logic [READ_LAT-1:0] last_p;

    logic [CW-1:0]       fifo_cnt;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [7:0]          mem_a    [FIFO_DEPTH];
    logic [7:0]          mem_b    [FIFO_DEPTH];
    logic                mem_last [FIFO_DEPTH];

    logic [7:0]          occ;
    logic                can_issue;
    logic                push;
    logic                pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign len_clamped = (length > LW'(NBytes)) ? LW'(NBytes) : length;
    assign last_idx    = len - LW'(1);

    assign push      = vld_p[READ_LAT-1];
    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid & out_ready;

    // FWFT head; forced to zero while empty so idle outputs are well defined.
    assign out_a    = out_valid ? mem_a[rd_ptr]    : 8'd0;
    assign out_b    = out_valid ? mem_b[rd_ptr]    : 8'd0;
    assign out_last = out_valid ? mem_last[rd_ptr] : 1'b0;

    // Credit check: buffered pairs plus every read still in flight must fit.
    always_comb begin
        occ = 8'(fifo_cnt) + {7'd0, rd_en};
        for (int i = 0; i < READ_LAT; i++) begin
            occ = occ + {7'd0, vld_p[i]};
        end
        can_issue = (occ < 8'(FIFO_DEPTH));
    end

    // Control FSM: accepts start, issues reads under credit, signals completion.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            len       <= '0;
            issue_cnt <= '0;
            bram_addr <= '0;
            rd_en     <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            issue_cnt <= '0;
            bram_addr <= '0;
            rd_en     <= 1'b0;
            rd_last   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_en   <= 1'b0;
            rd_last <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        len       <= len_clamped;
                        issue_cnt <= '0;
                        if (len_clamped == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ISSUE;
                            busy  <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (can_issue) begin
                        rd_en     <= 1'b1;
                        bram_addr <= issue_cnt[AW-1:0];
                        rd_last   <= (issue_cnt == last_idx);
                        issue_cnt <= issue_cnt + LW'(1);
                        if (issue_cnt == last_idx) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Shift issued reads through the BRAM latency so the data arrival is known.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vld_p  <= '0;
            last_p <= '0;
        end else if (abort) begin
            vld_p  <= '0;
            last_p <= '0;
        end else begin
            vld_p[0]  <= rd_en;
            last_p[0] <= rd_last;
            for (int i = 1; i < READ_LAT; i++) begin
                vld_p[i]  <= vld_p[i-1];
                last_p[i] <= last_p[i-1];
            end
        end
    end

    // FIFO bookkeeping; push and pop in the same cycle leave the count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else if (abort) begin
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            assert (!(push && !pop && (fifo_cnt == CW'(FIFO_DEPTH))));
            if (push) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage: data only, validity comes from the count and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]    <= bramA_byte;
            mem_b[wr_ptr]    <= bramB_byte;
            mem_last[wr_ptr] <= last_p[READ_LAT-1];
        end
    end

endmodule

// File: tb/tb_vector_read_sequencer.sv
// Directed bench for vector_read_sequencer with a behavioural 1-cycle BRAM pair.
// BRAM A holds (i+1) and BRAM B holds (i+1)*10 at address i, both mod 256.
module tb_vector_read_sequencer;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [10:0] length;
    logic        abort;
    logic [9:0]  bram_addr;
    logic        rd_en;
    logic [7:0]  bramA_byte;
    logic [7:0]  bramB_byte;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_a;
    logic [7:0]  out_b;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_a [1024];
    logic [7:0] mem_b [1024];

    vector_read_sequencer #(.NBytes(1024), .READ_LAT(1), .FIFO_DEPTH(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .length     (length),
        .abort      (abort),
        .bram_addr  (bram_addr),
        .rd_en      (rd_en),
        .bramA_byte (bramA_byte),
        .bramB_byte (bramB_byte),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Port-B BRAM model with one cycle of read latency.
    always @(posedge clk) begin
        if (rd_en) begin
            bramA_byte <= mem_a[bram_addr];
            bramB_byte <= mem_b[bram_addr];
        end
    end

    function automatic logic [7:0] exp_a(input int i);
        return 8'(i + 1);
    endfunction

    function automatic logic [7:0] exp_b(input int i);
        return 8'((i + 1) * 10);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs one pass already started; checks addresses, pair order, stalls and done.
    task automatic stream(input string tag, input int n, input int mode);
        int         got;
        int         addr;
        int         last_cyc;
        bit         done_seen;
        bit         prev_stall;
        logic [7:0] ha;
        logic [7:0] hb;
        logic       hl;
        got = 0; addr = 0; last_cyc = -10; done_seen = 0; prev_stall = 0;
        ha = 0; hb = 0; hl = 0;
        for (int cyc = 0; cyc < n * 3 + 20 && !done_seen; cyc++) begin
            if (mode == 0 && addr > 0 && addr < n)
                chk({tag, "_nobubble"}, rd_en, 1);
            if (rd_en) begin
                chk({tag, "_addr"}, {22'd0, bram_addr}, addr);
                chk({tag, "_rd_count"}, (addr < n), 1);
                addr++;
            end
            if (prev_stall) begin
                chk({tag, "_hold_valid"}, out_valid, 1);
                chk({tag, "_hold_a"}, out_a, ha);
                chk({tag, "_hold_b"}, out_b, hb);
                chk({tag, "_hold_last"}, out_last, hl);
            end
            if (done) begin
                chk({tag, "_done_timing"}, cyc, last_cyc + 1);
                chk({tag, "_pair_count"}, got, n);
                chk({tag, "_addr_count"}, addr, n);
                chk({tag, "_busy_at_done"}, busy, 0);
                done_seen = 1;
            end else begin
                out_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 0);
                if (out_valid && out_ready) begin
                    chk({tag, "_extra_pair"}, (got < n), 1);
                    chk({tag, "_a"}, out_a, exp_a(got));
                    chk({tag, "_b"}, out_b, exp_b(got));
                    chk({tag, "_last"}, out_last, (got == n - 1));
                    if (got == n - 1) last_cyc = cyc;
                    got++;
                end
                prev_stall = out_valid && !out_ready;
                ha = out_a; hb = out_b; hl = out_last;
                tick();
            end
        end
        chk({tag, "_timeout"}, done_seen, 1);
    endtask

    initial begin
        int got;
        for (int i = 0; i < 1024; i++) begin
            mem_a[i] = exp_a(i);
            mem_b[i] = exp_b(i);
        end
        bramA_byte = 8'd0;
        bramB_byte = 8'd0;
        resetn     = 1'b0;
        start      = 1'b0;
        length     = 11'd0;
        abort      = 1'b0;
        out_ready  = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_bram_addr", bram_addr, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_a", out_a, 0);
        chk("rst_out_b", out_b, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        tick();

        // Length 4, consumer always ready: exact cycle timing
        start = 1'b1; length = 11'd4; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_busy_k", busy, 1);
        chk("t4_rd_en_k", rd_en, 0);
        tick();
        chk("t4_busy_k1", busy, 1);
        chk("t4_rd_en_k1", rd_en, 1);
        chk("t4_addr_k1", bram_addr, 0);
        chk("t4_valid_k1", out_valid, 0);
        tick();
        chk("t4_valid_k2", out_valid, 0);
        chk("t4_rd_en_k2", rd_en, 1);
        chk("t4_addr_k2", bram_addr, 1);
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t4_valid", out_valid, 1);
            chk("t4_a", out_a, exp_a(i));
            chk("t4_b", out_b, exp_b(i));
            chk("t4_last", out_last, (i == 3));
            chk("t4_done_early", done, 0);
            tick();
        end
        chk("t4_done", done, 1);
        chk("t4_busy_end", busy, 0);
        chk("t4_valid_end", out_valid, 0);

        // Length 8 started in the done cycle, consumer toggling ready
        start = 1'b1; length = 11'd8;
        tick();
        start = 1'b0;
        chk("t8_done_cleared", done, 0);
        chk("t8_busy", busy, 1);
        stream("t8", 8, 1);

        // Length 0: done one cycle after start, nothing streamed
        tick();
        start = 1'b1; length = 11'd0;
        tick();
        start = 1'b0;
        chk("t0_done", done, 1);
        chk("t0_busy", busy, 0);
        chk("t0_valid", out_valid, 0);
        tick();
        chk("t0_done_pulse", done, 0);
        chk("t0_valid2", out_valid, 0);
        chk("t0_rd_en", rd_en, 0);
        chk("t0_busy2", busy, 0);

        // Full-depth pass and clamped over-length pass
        start = 1'b1; length = 11'd1024;
        tick();
        start = 1'b0;
        stream("t1024", 1024, 0);
        tick();
        start = 1'b1; length = 11'd2000;
        tick();
        start = 1'b0;
        stream("t2000", 1024, 0);

        // Abort after 5 pairs with the FIFO filled by a stalled consumer
        tick();
        start = 1'b1; length = 11'd16; out_ready = 1'b1;
        tick();
        start = 1'b0;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            if (out_valid) begin
                chk("ab_a", out_a, exp_a(got));
                chk("ab_b", out_b, exp_b(got));
                got++;
            end
            tick();
        end
        out_ready = 1'b0;
        chk("ab_got5", got, 5);
        repeat (8) tick();
        chk("ab_valid_before", out_valid, 1);
        chk("ab_busy_before", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_valid", out_valid, 0);
        chk("ab_busy", busy, 0);
        chk("ab_done", done, 0);
        chk("ab_rd_en", rd_en, 0);
        chk("ab_out_a", out_a, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("ab_no_residual", out_valid, 0);
            chk("ab_no_done", done, 0);
        end
        start = 1'b1; length = 11'd2;
        tick();
        start = 1'b0;
        stream("ab_len2", 2, 0);

        // Asynchronous reset mid-pass with the FIFO full
        tick();
        start = 1'b1; length = 11'd16; out_ready = 1'b0;
        tick();
        start = 1'b0;
        repeat (10) tick();
        chk("rs_valid_before", out_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("rs_valid", out_valid, 0);
        chk("rs_out_a", out_a, 0);
        chk("rs_out_b", out_b, 0);
        chk("rs_out_last", out_last, 0);
        chk("rs_busy", busy, 0);
        chk("rs_done", done, 0);
        chk("rs_rd_en", rd_en, 0);
        chk("rs_addr", bram_addr, 0);
        tick();
        tick();
        resetn = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("rs_no_residual", out_valid, 0);
            chk("rs_idle_busy", busy, 0);
        end
        start = 1'b1; length = 11'd3;
        tick();
        start = 1'b0;
        stream("rs_len3", 3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
